// File: rtl/simon_pkg.sv
// Types and constants shared by the button front end and the game FSM.
// The gesture state enum is reused by the game FSM for its input-phase decode.
package simon_pkg;

  localparam int N_BTN                   = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;  // 10 ms at 50 MHz

  typedef logic [1:0] btn_id_t;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    ARMED    = 2'd1,
    HOLD     = 2'd2
  } gesture_state_t;

endpackage

// File: rtl/btn_conditioner_if.sv
// Press-event handshake between the button conditioner (master) and the game FSM (slave).
interface btn_conditioner_if;
  import simon_pkg::*;

  logic    press_valid;
  btn_id_t press_id;
  logic    press_ready;

  modport master (
    output press_valid,
    output press_id,
    input  press_ready
  );

  modport slave (
    input  press_valid,
    input  press_id,
    output press_ready
  );

endinterface

// File: rtl/btn_debounce.sv
// Single-bit two-flop synchroniser followed by a stable-count debouncer.
// The level only changes after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the player buttons and turns each clean single-button press-and-release
// into one press event on a one-entry valid/ready slot; flags chords and dropped events.
module btn_conditioner
  import simon_pkg::*;
#(
  parameter int N_BTN           = simon_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BTN-1:0]   btn_raw,
  input  logic               enable,
  output logic [N_BTN-1:0]   btn_level,
  output logic               multi_press,
  output logic               overrun,
  btn_conditioner_if.master  press
);

  // After reset btn_level reads 0 until the debouncers have had time to see the
  // real pins; the FSM must not arm in that window or a button held through
  // reset would look like a fresh press.
  localparam int SETTLE_CYCLES = DEBOUNCE_CYCLES + 3;
  localparam int SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

  logic [SETTLE_W-1:0] settle_cnt;
  logic                settled;

  gesture_state_t state, state_next;
  btn_id_t        held_id, held_next;
  btn_id_t        first_idx;
  logic [N_BTN-1:0] held_mask;
  logic [N_BTN-1:0] others;
  int unsigned    ones;
  logic           emit;
  logic           chord;

  logic    slot_valid;
  btn_id_t slot_id;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .level (btn_level[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign settled = (settle_cnt == SETTLE_W'(SETTLE_CYCLES));

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    held_mask          = '0;
    held_mask[held_id] = 1'b1;
    others             = btn_level & ~held_mask;
    ones               = $countones(btn_level);
    first_idx          = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_level[i]) first_idx = btn_id_t'(i);
    end
  end

  always_comb begin
    state_next = state;
    held_next  = held_id;
    emit       = 1'b0;
    chord      = 1'b0;
    unique case (state)
      WAIT_REL: begin
        if (settled && enable && btn_level == '0) state_next = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_next = WAIT_REL;
        end else if (ones == 1) begin
          held_next  = first_idx;
          state_next = HOLD;
        end else if (ones > 1) begin
          chord      = 1'b1;
          state_next = WAIT_REL;
        end
      end
      HOLD: begin
        // Another bit rising wins over the held bit falling in the same cycle.
        if (!enable) begin
          state_next = WAIT_REL;
        end else if (others != '0) begin
          chord      = 1'b1;
          state_next = WAIT_REL;
        end else if (btn_level == '0) begin
          emit       = 1'b1;
          state_next = ARMED;
        end
      end
      default: state_next = WAIT_REL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT_REL;
      held_id <= '0;
    end else begin
      state   <= state_next;
      held_id <= held_next;
    end
  end

  // One-entry event slot; a handshake in the emit cycle frees room for the new event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid  <= 1'b0;
      slot_id     <= '0;
      multi_press <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      multi_press <= chord;
      overrun     <= 1'b0;
      if (!enable) begin
        slot_valid <= 1'b0;
      end else if (emit) begin
        if (!slot_valid || press.press_ready) begin
          slot_valid <= 1'b1;
          slot_id    <= held_id;
        end else begin
          overrun <= 1'b1;
        end
      end else if (slot_valid && press.press_ready) begin
        slot_valid <= 1'b0;
      end
    end
  end

  assign press.press_valid = slot_valid;
  assign press.press_id    = slot_id;

endmodule
